// File: rtl/histogram_bram_sched.sv
// Per-frame phase scheduler and port arbiter for the shared histogram BRAM.
// Clears all bins, grants the accumulator, drains it, then runs the cumulative-sum engine.
module histogram_bram_sched #(
    parameter int WD_BRAM_ADR    = 8,
    parameter int WD_BRAM_DAT    = 32,
    parameter int WD_ERR_INFO    = 4,
    parameter int NB_BRAM_LATCH  = 2,
    parameter int NB_SUM_TIMEOUT = 2048
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   s_frame_start,
    input  logic                   s_frame_end,
    input  logic                   s_stat_enb,
    input  logic [WD_BRAM_ADR-1:0] s_stat_addrb,
    input  logic                   s_stat_ena,
    input  logic                   s_stat_wea,
    input  logic [WD_BRAM_ADR-1:0] s_stat_addra,
    input  logic [WD_BRAM_DAT-1:0] s_stat_dina,
    input  logic                   s_sum_enb,
    input  logic [WD_BRAM_ADR-1:0] s_sum_addrb,
    input  logic                   s_sum_ena,
    input  logic                   s_sum_wea,
    input  logic [WD_BRAM_ADR-1:0] s_sum_addra,
    input  logic [WD_BRAM_DAT-1:0] s_sum_dina,
    input  logic                   s_sum_done,
    output logic                   m_sum_grant,
    output logic                   m_sum_start,
    output logic                   m_bram_enb,
    output logic [WD_BRAM_ADR-1:0] m_bram_addrb,
    output logic                   m_bram_ena,
    output logic                   m_bram_wea,
    output logic [WD_BRAM_ADR-1:0] m_bram_addra,
    output logic [WD_BRAM_DAT-1:0] m_bram_dina,
    output logic                   m_busy,
    output logic                   m_frame_ready,
    output logic [WD_ERR_INFO-1:0] m_err_info
);

    localparam int WD_CLR   = WD_BRAM_ADR + 1;
    localparam int NB_DRAIN = NB_BRAM_LATCH + 2;
    localparam int WD_DRN   = $clog2(NB_DRAIN + 1);
    localparam int WD_WDG   = $clog2(NB_SUM_TIMEOUT + 1);

    localparam logic [WD_CLR-1:0] CLR_LAST = WD_CLR'((2 ** WD_BRAM_ADR) - 1);
    localparam logic [WD_DRN-1:0] DRN_LAST = WD_DRN'(NB_DRAIN - 1);
    localparam logic [WD_WDG-1:0] WDG_LAST = WD_WDG'(NB_SUM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SUM   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                 state_r;
    logic [WD_CLR-1:0]      clr_cnt_r;
    logic [WD_DRN-1:0]      drn_cnt_r;
    logic [WD_WDG-1:0]      wdg_cnt_r;
    logic                   timeout_s;
    logic [WD_ERR_INFO-1:0] err_evt_s;

    // Protocol violations and watchdog expiry detected this cycle
    always_comb begin
        timeout_s    = (state_r == ST_SUM) && !s_sum_done && (wdg_cnt_r == WDG_LAST);
        err_evt_s    = '0;
        err_evt_s[0] = s_frame_start && (state_r != ST_IDLE);
        err_evt_s[1] = s_frame_end && (state_r != ST_ACCUM);
        err_evt_s[2] = timeout_s;
        err_evt_s[3] = (s_stat_ena || s_stat_enb) &&
                       !((state_r == ST_ACCUM) || (state_r == ST_DRAIN));
    end

    // Phase sequencer with registered control outputs and sticky error flags
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_r       <= ST_IDLE;
            clr_cnt_r     <= '0;
            drn_cnt_r     <= '0;
            wdg_cnt_r     <= '0;
            m_busy        <= 1'b0;
            m_sum_grant   <= 1'b0;
            m_sum_start   <= 1'b0;
            m_frame_ready <= 1'b0;
            m_err_info    <= '0;
        end else begin
            m_sum_start   <= 1'b0;
            m_frame_ready <= 1'b0;
            m_err_info    <= m_err_info | err_evt_s;
            case (state_r)
                ST_IDLE: begin
                    if (s_frame_start) begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= '0;
                        m_busy    <= 1'b1;
                    end else begin
                        m_busy    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r   <= ST_ACCUM;
                        clr_cnt_r <= '0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (s_frame_end) begin
                        state_r   <= ST_DRAIN;
                        drn_cnt_r <= '0;
                    end else begin
                        state_r   <= ST_ACCUM;
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt_r == DRN_LAST) begin
                        state_r     <= ST_SUM;
                        drn_cnt_r   <= '0;
                        wdg_cnt_r   <= '0;
                        m_sum_start <= 1'b1;
                        m_sum_grant <= 1'b1;
                    end else begin
                        drn_cnt_r   <= drn_cnt_r + 1'b1;
                    end
                end
                ST_SUM: begin
                    // Completion on the expiry cycle still counts as a good frame
                    if (s_sum_done) begin
                        state_r       <= ST_DONE;
                        m_sum_grant   <= 1'b0;
                        m_frame_ready <= 1'b1;
                    end else if (timeout_s) begin
                        state_r     <= ST_IDLE;
                        m_sum_grant <= 1'b0;
                        m_busy      <= 1'b0;
                    end else begin
                        wdg_cnt_r   <= wdg_cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    m_busy  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    m_busy      <= 1'b0;
                    m_sum_grant <= 1'b0;
                end
            endcase
        end
    end

    // BRAM port mux: only the phase owner reaches the memory, zero added latency
    always_comb begin
        m_bram_enb   = 1'b0;
        m_bram_addrb = '0;
        m_bram_ena   = 1'b0;
        m_bram_wea   = 1'b0;
        m_bram_addra = '0;
        m_bram_dina  = '0;
        case (state_r)
            ST_CLEAR: begin
                m_bram_ena   = 1'b1;
                m_bram_wea   = 1'b1;
                m_bram_addra = clr_cnt_r[WD_BRAM_ADR-1:0];
            end
            ST_ACCUM, ST_DRAIN: begin
                m_bram_enb   = s_stat_enb;
                m_bram_addrb = s_stat_addrb;
                m_bram_ena   = s_stat_ena;
                m_bram_wea   = s_stat_wea;
                m_bram_addra = s_stat_addra;
                m_bram_dina  = s_stat_dina;
            end
            ST_SUM: begin
                m_bram_enb   = s_sum_enb;
                m_bram_addrb = s_sum_addrb;
                m_bram_ena   = s_sum_ena;
                m_bram_wea   = s_sum_wea;
                m_bram_addra = s_sum_addra;
                m_bram_dina  = s_sum_dina;
            end
            default: begin
                m_bram_enb = 1'b0;
                m_bram_ena = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/histogram_bram_sched.md
Name: histogram_bram_sched

Overview:
- Per-frame phase scheduler and port arbiter for the shared histogram BRAM.
- Sequences each frame as: clear all bins, grant the pixel-statistics accumulator, drain its pipeline, start and grant the histogram cumulative-sum engine, then flag the frame ready.
- Sits between the BRAM and its two requesters. Drives the sum engine's idle/grant input and its start pulse.

Parameters:
- WD_BRAM_ADR, 8, BRAM address width; bin count = 2^WD_BRAM_ADR.
- WD_BRAM_DAT, 32, BRAM data width.
- WD_ERR_INFO, 4, error vector width.
- NB_BRAM_LATCH, 2, BRAM read latency; sets the drain length.
- NB_SUM_TIMEOUT, 2048, maximum SUM-phase cycles before abort.

Ports:
- i_sys_clk  in  1  system clock
- i_sys_resetn  in  1  asynchronous active-low reset
- s_frame_start  in  1  one-cycle pulse, frame begins
- s_frame_end  in  1  one-cycle pulse, last pixel accumulated
- s_stat_enb / s_stat_addrb  in  1 / WD_BRAM_ADR  accumulator read request
- s_stat_ena / s_stat_wea / s_stat_addra / s_stat_dina  in  1/1/WD_BRAM_ADR/WD_BRAM_DAT  accumulator write request
- s_sum_enb / s_sum_addrb  in  1 / WD_BRAM_ADR  sum-engine read request
- s_sum_ena / s_sum_wea / s_sum_addra / s_sum_dina  in  1/1/WD_BRAM_ADR/WD_BRAM_DAT  sum-engine write request
- s_sum_done  in  1  sum engine finished pulse
- m_sum_grant  out  1  drives sum engine idle input; high only in SUM
- m_sum_start  out  1  one-cycle start pulse to sum engine
- m_bram_enb / m_bram_addrb  out  1 / WD_BRAM_ADR  BRAM port B
- m_bram_ena / m_bram_wea / m_bram_addra / m_bram_dina  out  1/1/WD_BRAM_ADR/WD_BRAM_DAT  BRAM port A
- m_busy  out  1  high in any state except IDLE
- m_frame_ready  out  1  one-cycle pulse, histogram complete
- m_err_info  out  WD_ERR_INFO  sticky error flags

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, m_err_info cleared. Reset mid-phase aborts immediately with no further BRAM writes.
- States: IDLE, CLEAR, ACCUM, DRAIN, SUM, DONE (registered state).
- IDLE: s_frame_start moves to CLEAR next cycle.
- CLEAR:
  - Scheduler drives ena=wea=1, dina=0, addra = counter 0..2^WD_BRAM_ADR-1, one bin per cycle; enb=0.
  - After the last address goes to ACCUM, so CLEAR lasts exactly 2^WD_BRAM_ADR cycles.
- ACCUM:
  - BRAM ports are a combinational pass-through of the s_stat_* signals (zero added latency).
  - s_frame_end moves to DRAIN.
- DRAIN:
  - Stat pass-through continues for NB_BRAM_LATCH+2 cycles so the read-modify-write pipeline can finish.
  - Then goes to SUM; m_sum_start pulses on the first SUM cycle.
- SUM:
  - m_sum_grant=1; BRAM ports pass through s_sum_*.
  - s_sum_done moves to DONE.
  - A watchdog counts SUM cycles. On reaching NB_SUM_TIMEOUT: set err bit2, go IDLE, no ready pulse.
- DONE: m_frame_ready=1 for one cycle, then IDLE.
- Outside their grant phase, requester signals are ignored and BRAM en/we are forced to 0.
- Error bits (sticky until reset):
  - bit0: s_frame_start outside IDLE; the pulse is ignored.
  - bit1: s_frame_end outside ACCUM; ignored.
  - bit2: SUM timeout.
  - bit3: s_stat_ena or s_stat_enb asserted outside ACCUM/DRAIN; the request is dropped.
  - Bits above 3 tie to 0.
- Simultaneous events:
  - s_frame_start and s_frame_end in the same IDLE cycle: start taken, err bit1 set.
  - s_sum_done on the same cycle the timeout is reached: done wins, no error.
- Counters are WD_BRAM_ADR+1 bits for clear; the timeout counter is wide enough for NB_SUM_TIMEOUT. No wrap-around within a phase.

Test Plan:
- Reset, then pulse s_frame_start -> m_busy rises next cycle; 256 consecutive writes of 0 to addra 0..255; state ACCUM on cycle 257.
- In ACCUM, drive s_stat_addra=0x12, dina=5, ena=wea=1 -> m_bram_addra=0x12, m_bram_dina=5 in the same cycle. After s_frame_end, passthrough lasts exactly 4 cycles (NB_BRAM_LATCH=2); m_sum_start pulses once on the following cycle.
- SUM with s_sum_done after 300 cycles -> m_sum_grant high throughout; m_frame_ready pulses once; m_busy drops the next cycle; m_err_info=0.
- SUM with no s_sum_done -> after 2048 cycles m_err_info[2]=1, returns to IDLE, no m_frame_ready.
- s_frame_start during CLEAR plus s_stat_ena during SUM -> err bits 0 and 3 set; CLEAR sequence continues uninterrupted; stat write is not seen on m_bram_ena.
- Deassert i_sys_resetn at CLEAR address 100 -> all outputs 0 asynchronously; after release, IDLE with no BRAM activity until the next s_frame_start.
